pwm_duty_meter: RTL and testbench

//  Receive-side counterpart of the motor PWM generator: samples one PWM line.

---
 rtl/pwm_pkg.sv | 44 ++++
 rtl/pwm_edge_sync.sv | 78 +++++++
 rtl/pwm_duty_meter.sv | 173 +++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter.
// Build option: PWM_GLITCH_FILTER_EN adds a majority filter, which lengthens edge-detector warm-up.
`timescale 1ns/1ps
package pwm_pkg;

    typedef enum logic [2:0] {
        LVL_OFF = 3'd0,
        LVL_300 = 3'd1,
        LVL_600 = 3'd2,
        LVL_800 = 3'd3,
        LVL_999 = 3'd4
    } level_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Nominal thresholds in generator ticks; scaled by CLK_PER_TICK at use.
    localparam int unsigned THR_300    = 150;
    localparam int unsigned THR_600    = 450;
    localparam int unsigned THR_800    = 700;
    localparam int unsigned THR_999    = 900;
    localparam int unsigned NOM_PERIOD = 1000;

    // Cycles after reset before the edge detector's history reflects the pin.
`ifdef PWM_GLITCH_FILTER_EN
    localparam int unsigned EDGE_WARM_CYCLES = 5;
`else
    localparam int unsigned EDGE_WARM_CYCLES = 3;
`endif

    function automatic level_e classify(input logic [31:0] high, input int unsigned tick);
        level_e lvl;
        if (high < THR_300 * tick)      lvl = LVL_OFF;
        else if (high < THR_600 * tick) lvl = LVL_300;
        else if (high < THR_800 * tick) lvl = LVL_600;
        else if (high < THR_999 * tick) lvl = LVL_800;
        else                            lvl = LVL_999;
        return lvl;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser, optional 3-sample majority filter (PWM_GLITCH_FILTER_EN) and registered edge pulses.
// Edges are suppressed until the pipeline has filled after reset, so a line held high is not a rise.
`timescale 1ns/1ps
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall,
    output logic o_line
);

    logic r_sync1;
    logic r_sync2;
    logic w_clean;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    logic r_hist0;
    logic r_hist1;
    logic r_filt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hist0 <= 1'b0;
            r_hist1 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_filt  <= (r_sync2 & r_hist0) | (r_sync2 & r_hist1) | (r_hist0 & r_hist1);
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = r_sync2;
`endif

    logic       r_prev;
    logic       r_rise;
    logic       r_fall;
    logic [2:0] r_warm;
    logic       w_armed;

    assign w_armed = (r_warm == 3'(EDGE_WARM_CYCLES));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_warm <= 3'd0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            if (!w_armed) r_warm <= r_warm + 3'd1;
            r_prev <= w_clean;
            r_rise <= w_armed &  w_clean & ~r_prev;
            r_fall <= w_armed & ~w_clean &  r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_line = r_prev;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of one PWM line and classifies the duty level.
// Build option: PWM_GLITCH_FILTER_EN (see pwm_edge_sync) rejects 1-cycle pulses.
`timescale 1ns/1ps
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned CLK_PER_TICK = 1,
    parameter int unsigned TIMEOUT      = 4096,
    parameter int unsigned PERIOD_TOL   = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pwm,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic [2:0]       o_level,
    output logic             o_period_err,
    output logic             o_stuck
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam int unsigned      NOM    = NOM_PERIOD * CLK_PER_TICK;
    localparam int unsigned      PER_LO = (NOM > PERIOD_TOL) ? NOM - PERIOD_TOL : 0;
    localparam int unsigned      PER_HI = NOM + PERIOD_TOL;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic w_rise;
    logic w_fall;
    logic w_line;

    pwm_edge_sync u_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pwm     (i_pwm),
        .o_rise    (w_rise),
        .o_fall    (w_fall),
        .o_line    (w_line)
    );

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period_cnt;
    logic             w_tmo_hit;
    logic             w_start;
    logic             w_capture;
    logic             w_timeout;

    assign w_tmo_hit = (r_period_cnt == TMO);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_HIGH;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                // A rise on the timeout cycle still completes a normal measurement.
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = ST_HIGH;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The rise cycle itself is the first cycle of the new period and high phase.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
        end else if (w_start) begin
            r_high_cnt   <= CNT_W'(1);
            r_period_cnt <= CNT_W'(1);
        end else if (w_timeout) begin
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_period_cnt <= sat_inc(r_period_cnt);
                ST_HIGH: begin
                    r_period_cnt <= sat_inc(r_period_cnt);
                    if (!w_fall) r_high_cnt <= sat_inc(r_high_cnt);
                end
                ST_LOW:  r_period_cnt <= sat_inc(r_period_cnt);
                default: r_period_cnt <= r_period_cnt;
            endcase
        end
    end

    level_e      w_level_cap;
    logic [31:0] w_period32;
    logic        w_period_err;

    assign w_level_cap  = classify(32'(r_high_cnt), CLK_PER_TICK);
    assign w_period32   = 32'(r_period_cnt);
    assign w_period_err = (w_period32 < PER_LO) || (w_period32 > PER_HI);

    logic             r_valid;
    logic [CNT_W-1:0] r_out_high;
    logic [CNT_W-1:0] r_out_period;
    level_e           r_level;
    logic             r_period_err;
    logic             r_stuck;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid      <= 1'b0;
            r_out_high   <= '0;
            r_out_period <= '0;
            r_level      <= LVL_OFF;
            r_period_err <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_valid      <= 1'b1;
                r_out_high   <= r_high_cnt;
                r_out_period <= r_period_cnt;
                r_level      <= w_level_cap;
                r_period_err <= w_period_err;
                r_stuck      <= 1'b0;
            end else if (w_timeout) begin
                r_valid      <= 1'b1;
                r_out_high   <= w_line ? TMO : '0;
                r_out_period <= TMO;
                r_level      <= w_line ? LVL_999 : LVL_OFF;
                r_period_err <= 1'b0;
                r_stuck      <= 1'b1;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_high_cnt   = r_out_high;
    assign o_period_cnt = r_out_period;
    assign o_level      = r_level;
    assign o_period_err = r_period_err;
    assign o_stuck      = r_stuck;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: directed PWM waveforms push expected measurements,
// and a monitor pops and compares on every o_valid.
`timescale 1ns/1ps
module tb_pwm_duty_meter;

    localparam int CNT_W = 20;

`ifdef PWM_GLITCH_FILTER_EN
    localparam int HI_TOP = 995;   // a 1-cycle low gap would be filtered away
`else
    localparam int HI_TOP = 999;
`endif

    typedef struct {
        int high;
        int period;
        int level;
        int err;
        int stuck;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             pwm;
    logic             o_valid;
    logic [CNT_W-1:0] o_high_cnt;
    logic [CNT_W-1:0] o_period_cnt;
    logic [2:0]       o_level;
    logic             o_period_err;
    logic             o_stuck;

    pwm_duty_meter dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_pwm        (pwm),
        .o_valid      (o_valid),
        .o_high_cnt   (o_high_cnt),
        .o_period_cnt (o_period_cnt),
        .o_level      (o_level),
        .o_period_err (o_period_err),
        .o_stuck      (o_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    exp_t pend;
    bit   pend_ok;
    exp_t mon_e;
    int   n_tests;
    int   n_fail;
    int   n_valid;
    int   n_pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int h, input int p, input int l, input int e, input int s);
        exp_t x;
        x.high = h; x.period = p; x.level = l; x.err = e; x.stuck = s;
        q.push_back(x);
        n_pushed++;
    endtask

    task automatic close_pending();
        if (pend_ok) push(pend.high, pend.period, pend.level, pend.err, pend.stuck);
        pend_ok = 1'b0;
    endtask

    task automatic set_pending(input int h, input int p, input int l, input int e);
        pend.high = h; pend.period = p; pend.level = l; pend.err = e; pend.stuck = 0;
        pend_ok = 1'b1;
    endtask

    // One PWM period starting with a rise; that rise completes the previous period.
    task automatic pwm_period(input int hi, input int per, input int lvl, input int err);
        close_pending();
        set_pending(hi, per, lvl, err);
        pwm = 1'b1;
        repeat (hi) @(negedge clk);
        pwm = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},  32'(o_valid), 0);
        check({tag, "_high"},   32'(o_high_cnt), 0);
        check({tag, "_period"}, 32'(o_period_cnt), 0);
        check({tag, "_level"},  32'(o_level), 0);
        check({tag, "_err"},    32'(o_period_err), 0);
        check({tag, "_stuck"},  32'(o_stuck), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            n_valid++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got high=%0d period=%0d level=%0d stuck=%0d, expected no o_valid",
                         o_high_cnt, o_period_cnt, o_level, o_stuck);
            end else begin
                mon_e = q.pop_front();
                check("meas_high",   32'(o_high_cnt),   32'(mon_e.high));
                check("meas_period", 32'(o_period_cnt), 32'(mon_e.period));
                check("meas_level",  32'(o_level),      32'(mon_e.level));
                check("meas_err",    32'(o_period_err), 32'(mon_e.err));
                check("meas_stuck",  32'(o_stuck),      32'(mon_e.stuck));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of stimulus, expected completion within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_valid = 0; n_pushed = 0; pend_ok = 1'b0;
        pwm   = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Basic 300/1000: nothing reported until the second rise.
        pwm_period(300, 1000, 1, 0);
        check("no_valid_before_2nd_rise", 32'(n_valid), 0);
        pwm_period(300, 1000, 1, 0);
        pwm_period(300, 1000, 1, 0);

        // Duty sweep.
        pwm_period(600, 1000, 2, 0);
        pwm_period(800, 1000, 3, 0);
        pwm_period(HI_TOP, 1000, 4, 0);

        // Period out of tolerance, then back in.
        pwm_period(300, 1020, 1, 1);
        pwm_period(300, 1000, 1, 0);

        // Line stuck low: one rise, a short high, then silence past the timeout.
        close_pending();
        pwm = 1'b1;
        repeat (300) @(negedge clk);
        pwm = 1'b0;
        push(0, 4096, 0, 0, 1);
        repeat (5000) @(negedge clk);

        // Line stuck high.
        push(4096, 4096, 4, 0, 1);
        pwm = 1'b1;
        repeat (5000) @(negedge clk);
        pwm = 1'b0;
        repeat (100) @(negedge clk);

        // Reset in the middle of a high phase.
        pwm_period(300, 1000, 1, 0);
        close_pending();
        pwm = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        pwm = 1'b0;
        repeat (700) @(negedge clk);
        check("no_valid_after_reset", 32'(q.size()), 0);
        pwm_period(300, 1000, 1, 0);
        pwm_period(600, 1000, 2, 0);

        // One-cycle glitch 700 cycles into a 300/1000 period.
        close_pending();
        pwm = 1'b1;
        repeat (300) @(negedge clk);
        pwm = 1'b0;
        repeat (400) @(negedge clk);
`ifdef PWM_GLITCH_FILTER_EN
        set_pending(300, 1000, 1, 0);
`else
        push(300, 700, 1, 1, 0);
        set_pending(1, 300, 0, 1);
`endif
        pwm = 1'b1;
        @(negedge clk);
        pwm = 1'b0;
        repeat (299) @(negedge clk);
        pwm_period(800, 1000, 3, 0);

        // Final rise closes the last period.
        close_pending();
        pwm = 1'b1;
        repeat (50) @(negedge clk);
        pwm = 1'b0;

        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(q.size()), 0);
        check("valid_count", 32'(n_valid), 32'(n_pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
